line_fetch_unit: RTL and testbench

//  AXI3 read-burst initiator that fetches one cache line per request and hands the assembled line to the cache.

---
 rtl/cache_pkg.sv | 44 ++++
 rtl/line_assembler.sv | 58 +++++
 rtl/line_fetch_unit.sv | 136 +++++++++++++
 tb/tb_line_fetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache/AXI3 types and line-geometry derivations for the refill path.
package cache_pkg;

    typedef logic [31:0] phys_t;
    typedef logic [7:0]  uint8_t;

    localparam int unsigned WORD_BITS      = 32;
    localparam int unsigned DEF_LINE_WIDTH = 256;

    // AXI3 caps INCR bursts at 16 beats.
    localparam int unsigned BURST_LIMIT = 16;

    function automatic int unsigned beats_of(input int unsigned line_width);
        return line_width / WORD_BITS;
    endfunction

    function automatic int unsigned byte_offset_of(input int unsigned line_width);
        return $clog2(line_width / 8);
    endfunction

    localparam int unsigned BEATS            = beats_of(DEF_LINE_WIDTH);
    localparam int unsigned LINE_BYTE_OFFSET = byte_offset_of(DEF_LINE_WIDTH);

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StDone
    } fsm_state_t;

endpackage

// File: rtl/line_assembler.sv
// Beat counter plus rotating word-slot writer that builds a cache line from
// successive 32-bit read beats, starting at an arbitrary slot.
module line_assembler
    import cache_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [$clog2(LINE_WIDTH/32)-1:0]     start_idx,
    input  logic                                 beat_en,
    input  logic [31:0]                          wdata,
    output logic [$clog2(LINE_WIDTH/32)-1:0]     beat_cnt,
    output logic                                 last_beat,
    output logic [LINE_WIDTH-1:0]                line_data
);

    localparam int unsigned Beats = beats_of(LINE_WIDTH);
    localparam int unsigned IdxW  = $clog2(Beats);

    logic [IdxW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [IdxW-1:0]       start_idx_q, start_idx_d;
    logic [IdxW-1:0]       slot;
    logic [LINE_WIDTH-1:0] line_data_q, line_data_d;

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        start_idx_d = start_idx_q;
        line_data_d = line_data_q;
        // Slot index wraps naturally because Beats is a power of two.
        slot        = start_idx_q + beat_cnt_q;
        if (start) begin
            beat_cnt_d  = '0;
            start_idx_d = start_idx;
        end else if (beat_en) begin
            line_data_d[slot*32 +: 32] = wdata;
            beat_cnt_d                 = beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            start_idx_q <= '0;
            line_data_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            start_idx_q <= start_idx_d;
            line_data_q <= line_data_d;
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign last_beat = (beat_cnt_q == IdxW'(Beats - 1));
    assign line_data = line_data_q;

endmodule

// File: rtl/line_fetch_unit.sv
// AXI3 read-burst initiator: fetches one cache line per request and hands it to the cache.
// Define LINE_FETCH_CWF_EN for critical-word-first (WRAP burst from the requested word).
module line_fetch_unit
    import cache_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned BUS_WIDTH  = 4,
    parameter int unsigned AWID       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [31:0]           req_addr,
    output logic                  req_ready,
    output logic [LINE_WIDTH-1:0] line_data,
    output logic                  line_vld,
    output logic                  line_err,
    output logic [31:0]           word_data,
    output logic                  word_vld,
    output logic [BUS_WIDTH-1:0]  arid,
    output logic [31:0]           araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [BUS_WIDTH-1:0]  rid,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int unsigned Beats   = beats_of(LINE_WIDTH);
    localparam int unsigned IdxW    = $clog2(Beats);
    localparam int unsigned ByteOff = byte_offset_of(LINE_WIDTH);

    fsm_state_t      state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic            err_q, err_d;
    logic            accept;
    logic            beat_hs;
    logic            last_beat;
    logic [IdxW-1:0] beat_cnt;
    logic [IdxW-1:0] start_idx;

    assign accept  = (state_q == StIdle) && req;
    assign beat_hs = (state_q == StData) && rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req)                   state_d = StAddr;
            StAddr: if (arready)               state_d = StData;
            StData: if (beat_hs && last_beat)  state_d = StDone;
            StDone:                            state_d = StIdle;
            default:                           state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        arvalid   = (state_q == StAddr);
        rready    = (state_q == StData);
        line_vld  = (state_q == StDone);
    end

    // Error flag: sticky over the burst, cleared when the next request is taken.
    always_comb begin
        addr_d = addr_q;
        err_d  = err_q;
        if (accept) begin
            addr_d = req_addr;
            err_d  = 1'b0;
        end else if (beat_hs) begin
            err_d = err_q | (rresp != RespOkay) | (rlast != last_beat);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    assign line_err = err_q;
    assign arid     = BUS_WIDTH'(AWID);
    assign arlen    = 4'(Beats - 1);
    assign arsize   = 3'b010;

`ifdef LINE_FETCH_CWF_EN
    logic unused_bits;
    assign unused_bits = ^{rid, addr_q[1:0]};
    assign araddr      = {addr_q[31:2], 2'b00};
    assign arburst     = BurstWrap;
    assign start_idx   = req_addr[ByteOff-1:2];
    assign word_vld    = beat_hs && (beat_cnt == '0);
    assign word_data   = word_vld ? rdata : 32'h0;
`else
    logic unused_bits;
    assign unused_bits = ^{rid, addr_q[ByteOff-1:0]};
    assign araddr      = {addr_q[31:ByteOff], {ByteOff{1'b0}}};
    assign arburst     = BurstIncr;
    assign start_idx   = '0;
    assign word_vld    = 1'b0;
    assign word_data   = 32'h0;
`endif

    line_assembler #(
        .LINE_WIDTH (LINE_WIDTH)
    ) u_line_assembler (
        .clk       (clk),
        .rst       (rst),
        .start     (accept),
        .start_idx (start_idx),
        .beat_en   (beat_hs),
        .wdata     (rdata),
        .beat_cnt  (beat_cnt),
        .last_beat (last_beat),
        .line_data (line_data)
    );

endmodule

// File: tb/tb_line_fetch_unit.sv
// Self-checking bench for line_fetch_unit: bench-side AXI3 read slave plus a line-level model.
module tb_line_fetch_unit;

    localparam int NB = 8;
`ifdef LINE_FETCH_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic         clk, rst, req, req_ready, line_vld, line_err, word_vld;
    logic [31:0]  req_addr, word_data, araddr, rdata;
    logic [255:0] line_data;
    logic [3:0]   arid, arlen, rid;
    logic [2:0]   arsize;
    logic [1:0]   arburst, rresp;
    logic         arvalid, arready, rlast, rvalid, rready;

    int errors = 0;
    int checks = 0;

    logic [31:0]  beat_data [NB];

    logic [31:0]  obs_araddr;
    logic [3:0]   obs_arlen, obs_arid;
    logic [2:0]   obs_arsize;
    logic [1:0]   obs_arburst;
    int           obs_ar_cycles, obs_vld_cnt, obs_word_cnt;
    bit           obs_ar_unstable, obs_rready_early, obs_first_arvalid, obs_timeout;
    bit           obs_err_after_accept, obs_vld_next, obs_word_on_first;
    logic [255:0] obs_line;
    logic         obs_err;
    logic [31:0]  obs_word;

    line_fetch_unit #(
        .LINE_WIDTH (256),
        .BUS_WIDTH  (4),
        .AWID       (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .line_data (line_data),
        .line_vld  (line_vld),
        .line_err  (line_err),
        .word_data (word_data),
        .word_vld  (word_vld),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference model: beat k lands in word slot (start + k) mod 8.
    function automatic logic [255:0] exp_line(input logic [31:0] addr);
        logic [255:0] l;
        int s;
        l = '0;
        s = CWF ? int'(addr[4:2]) : 0;
        for (int k = 0; k < NB; k++) l[((s + k) % NB)*32 +: 32] = beat_data[k];
        return l;
    endfunction

    function automatic logic [31:0] exp_araddr(input logic [31:0] addr);
        return CWF ? (addr & 32'hffff_fffc) : (addr & 32'hffff_ffe0);
    endfunction

    function automatic logic exp_err(input int err_beat, input int rlast_beat);
        return (err_beat >= 0 && err_beat < NB) || (rlast_beat != NB - 1);
    endfunction

    // Bench-side slave: drives one full request/burst and records what the DUT did.
    task automatic do_fetch(input logic [31:0] addr, input int ar_wait, input int gap_mode,
                            input int err_beat, input int rlast_beat);
        int beat, cyc;
        bit gap;
        obs_ar_cycles = 0; obs_vld_cnt = 0; obs_word_cnt = 0; obs_ar_unstable = 0;
        obs_rready_early = 0; obs_first_arvalid = 0; obs_timeout = 0; obs_word_on_first = 0;
        obs_err_after_accept = 1'b1; obs_vld_next = 0; obs_word = '0;
        @(posedge clk); #1;
        cyc = 0;
        while (!req_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        if (!req_ready) obs_timeout = 1;
        req = 1'b1; req_addr = addr;
        @(posedge clk); #1;
        req = 1'b0; req_addr = $urandom();
        for (int i = 0; i <= ar_wait; i++) begin
            arready = (i == ar_wait);
            @(negedge clk);
            if (i == 0) begin
                obs_first_arvalid = arvalid; obs_araddr = araddr; obs_arlen = arlen;
                obs_arsize = arsize; obs_arburst = arburst; obs_arid = arid;
                obs_err_after_accept = line_err;
            end else if (araddr !== obs_araddr || arlen !== obs_arlen ||
                         arburst !== obs_arburst || arid !== obs_arid) begin
                obs_ar_unstable = 1;
            end
            if (arvalid !== 1'b1) obs_ar_unstable = 1;
            if (rready !== 1'b0) obs_rready_early = 1;
            obs_ar_cycles++;
            @(posedge clk); #1;
        end
        arready = 1'b0;
        beat = 0; cyc = 0;
        while (beat < NB && cyc < 200) begin
            gap = (gap_mode == 1) ? (cyc % 2 == 1) :
                  (gap_mode == 2) ? ($urandom_range(0, 99) < 30) : 1'b0;
            if (gap) begin
                rvalid = 1'b0; rdata = $urandom(); rresp = 2'b10; rlast = 1'b1;
            end else begin
                rvalid = 1'b1; rdata = beat_data[beat];
                rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
                rlast  = (beat == rlast_beat);
            end
            @(negedge clk);
            if (line_vld) obs_vld_cnt++;
            if (word_vld) begin
                obs_word_cnt++; obs_word = word_data;
                if (rvalid && beat == 0) obs_word_on_first = 1;
            end
            if (rvalid && rready) beat++;
            cyc++;
            @(posedge clk); #1;
        end
        if (beat < NB) obs_timeout = 1;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        @(negedge clk);
        obs_vld_next = line_vld; obs_line = line_data; obs_err = line_err;
        if (line_vld) obs_vld_cnt++;
        if (word_vld) obs_word_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (line_vld) obs_vld_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; req_addr = '0; arready = 1'b0; rvalid = 1'b0;
        rdata = '0; rresp = '0; rlast = 1'b0; rid = 4'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", rready); end
        checks++; if ({line_vld, line_err, word_vld} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b want 000", {line_vld, line_err, word_vld}); end
        checks++; if (line_data !== '0) begin errors++; $display("FAIL reset_line_data: got %h want 0", line_data); end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] a;
        a = 32'h1fc0_0040;
        for (int k = 0; k < NB; k++) beat_data[k] = k;
        do_fetch(a, 0, 0, -1, NB - 1);
        checks++; if (obs_timeout) begin errors++; $display("FAIL basic_timeout: got 1 want 0"); end
        checks++; if (obs_first_arvalid !== 1'b1) begin errors++; $display("FAIL basic_arvalid_latency: got %b want 1", obs_first_arvalid); end
        checks++; if (obs_araddr !== exp_araddr(a)) begin errors++; $display("FAIL basic_araddr: got %h want %h", obs_araddr, exp_araddr(a)); end
        checks++; if (obs_arlen !== 4'd7) begin errors++; $display("FAIL basic_arlen: got %0d want 7", obs_arlen); end
        checks++; if (obs_arsize !== 3'b010) begin errors++; $display("FAIL basic_arsize: got %b want 010", obs_arsize); end
        checks++; if (obs_arburst !== (CWF ? 2'b10 : 2'b01)) begin errors++; $display("FAIL basic_arburst: got %b", obs_arburst); end
        checks++; if (obs_arid !== 4'd2) begin errors++; $display("FAIL basic_arid: got %0d want 2", obs_arid); end
        checks++; if (obs_line !== exp_line(a)) begin errors++; $display("FAIL basic_line: got %h want %h", obs_line, exp_line(a)); end
        checks++; if (obs_vld_next !== 1'b1 || obs_vld_cnt != 1) begin
            errors++; $display("FAIL basic_line_vld: got next=%b count=%0d want next=1 count=1", obs_vld_next, obs_vld_cnt); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL basic_line_err: got %b want 0", obs_err); end
    endtask

    task automatic test_ar_backpressure();
        logic [31:0] a;
        a = 32'h0000_1200;
        for (int k = 0; k < NB; k++) beat_data[k] = $urandom();
        do_fetch(a, 3, 0, -1, NB - 1);
        checks++; if (obs_ar_cycles != 4 || obs_ar_unstable) begin
            errors++; $display("FAIL arbp_stable: got cycles=%0d unstable=%0d want 4/0", obs_ar_cycles, obs_ar_unstable); end
        checks++; if (obs_rready_early) begin errors++; $display("FAIL arbp_rready_early: got 1 want 0"); end
        checks++; if (obs_line !== exp_line(a)) begin errors++; $display("FAIL arbp_line: got %h want %h", obs_line, exp_line(a)); end
    endtask

    task automatic test_r_gaps();
        logic [31:0] a;
        a = 32'h1fc0_0040;
        for (int k = 0; k < NB; k++) beat_data[k] = k;
        do_fetch(a, 0, 1, -1, NB - 1);
        checks++; if (obs_line !== exp_line(a)) begin errors++; $display("FAIL gaps_line: got %h want %h", obs_line, exp_line(a)); end
        checks++; if (obs_vld_cnt != 1 || obs_vld_next !== 1'b1) begin
            errors++; $display("FAIL gaps_line_vld: got count=%0d want 1", obs_vld_cnt); end
    endtask

    task automatic test_err_beat();
        logic [31:0] a;
        a = 32'h8000_0020;
        for (int k = 0; k < NB; k++) beat_data[k] = $urandom();
        do_fetch(a, 1, 0, 3, NB - 1);
        checks++; if (obs_vld_next !== 1'b1 || obs_err !== 1'b1) begin
            errors++; $display("FAIL err_beat: got vld=%b err=%b want 1/1", obs_vld_next, obs_err); end
        do_fetch(a + 32'h40, 0, 0, -1, NB - 1);
        checks++; if (obs_err_after_accept !== 1'b0) begin
            errors++; $display("FAIL err_clear_on_req: got %b want 0", obs_err_after_accept); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL err_next_line: got %b want 0", obs_err); end
    endtask

    task automatic test_early_rlast();
        logic [31:0] a;
        a = 32'h0040_0100;
        for (int k = 0; k < NB; k++) beat_data[k] = $urandom();
        do_fetch(a, 0, 0, -1, 5);
        checks++; if (obs_timeout || obs_vld_next !== 1'b1 || obs_vld_cnt != 1) begin
            errors++; $display("FAIL rlast_completion: got vld=%b count=%0d want 1/1", obs_vld_next, obs_vld_cnt); end
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL rlast_err: got %b want 1", obs_err); end
        checks++; if (obs_line !== exp_line(a)) begin errors++; $display("FAIL rlast_line: got %h want %h", obs_line, exp_line(a)); end
    endtask

    task automatic test_cwf_addr();
        logic [31:0] a;
        a = 32'h1fc0_004c;
        for (int k = 0; k < NB; k++) beat_data[k] = $urandom();
        do_fetch(a, 0, 0, -1, NB - 1);
        checks++; if (obs_araddr !== exp_araddr(a)) begin errors++; $display("FAIL cwf_araddr: got %h want %h", obs_araddr, exp_araddr(a)); end
        checks++; if (obs_arburst !== (CWF ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cwf_arburst: got %b", obs_arburst); end
        checks++; if (obs_line !== exp_line(a)) begin errors++; $display("FAIL cwf_line: got %h want %h", obs_line, exp_line(a)); end
        checks++; if (obs_word_cnt != (CWF ? 1 : 0)) begin
            errors++; $display("FAIL cwf_word_vld_count: got %0d want %0d", obs_word_cnt, CWF ? 1 : 0); end
        if (CWF) begin
            checks++; if (!obs_word_on_first || obs_word !== beat_data[0]) begin
                errors++; $display("FAIL cwf_word_data: got %h want %h", obs_word, beat_data[0]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int eb, lb;
        for (int n = 0; n < 10; n++) begin
            a  = $urandom();
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            lb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NB - 1)) : NB - 1;
            for (int k = 0; k < NB; k++) beat_data[k] = $urandom();
            do_fetch(a, int'($urandom_range(0, 3)), 2, eb, lb);
            checks++; if (obs_araddr !== exp_araddr(a) || obs_ar_unstable) begin
                errors++; $display("FAIL rand_araddr[%0d]: got %h want %h", n, obs_araddr, exp_araddr(a)); end
            checks++; if (obs_line !== exp_line(a)) begin
                errors++; $display("FAIL rand_line[%0d]: got %h want %h", n, obs_line, exp_line(a)); end
            checks++; if (obs_err !== exp_err(eb, lb) || obs_vld_cnt != 1) begin
                errors++; $display("FAIL rand_err_vld[%0d]: got err=%b cnt=%0d want err=%b cnt=1",
                                   n, obs_err, obs_vld_cnt, exp_err(eb, lb)); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int beat, cyc, vld_cnt;
        @(posedge clk); #1;
        req = 1'b1; req_addr = 32'h2000_0000; arready = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        beat = 0; cyc = 0;
        while (beat < 5 && cyc < 50) begin
            rvalid = 1'b1; rdata = $urandom(); rresp = 2'b00; rlast = 1'b0;
            @(negedge clk);
            if (rvalid && rready) beat++;
            cyc++;
            @(posedge clk); #1;
        end
        arready = 1'b0; rvalid = 1'b0;
        checks++; if (beat != 5) begin errors++; $display("FAIL rstmid_setup: got beats=%0d want 5", beat); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({arvalid, rready, req_ready, line_vld} !== 4'b0010) begin
            errors++; $display("FAIL rstmid_outputs: got arv/rr/rdy/vld=%b want 0010", {arvalid, rready, req_ready, line_vld}); end
        checks++; if (line_data !== '0) begin errors++; $display("FAIL rstmid_line_data: got %h want 0", line_data); end
        @(posedge clk); #1; rst = 1'b0;
        vld_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (line_vld) vld_cnt++;
        end
        checks++; if (vld_cnt != 0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_no_line_vld: got count=%0d ready=%b want 0/1", vld_cnt, req_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ar_backpressure();
        test_r_gaps();
        test_err_beat();
        test_early_rlast();
        test_cwf_addr();
        test_random();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
